// File: rtl/dcm_avg_ctrl.sv
// ----------------------------------------------------------------------------
// dcm_avg_ctrl
//   Duty-cycle-measurement sequencer for a thermometer-code pulse shrinker.
//   Each sample runs clear -> arm -> capture. The captured thermometer code is
//   converted to a count of leading ones and accumulated. Two-to-the-
//   SAMPLES_LOG2 samples are taken for each measured polarity. When the run is
//   complete, the per-polarity averages and their signed difference are
//   published and held until the consumer acknowledges them with finish.
//
// Ports
//   clk_in        measurement clock (posedge)
//   rst           asynchronous active-high reset
//   request       start a measurement (taken only when idle)
//   finish        consumer done with results (taken only in DONE)
//   mode[1:0]     0 = high phase only, 1 = low phase only, 2/3 = high then low
//   theta[LEVEL]  shrinker thermometer code, bit 0 = first stage
//   shrinker_rst  clear to shrinker / SR latches (1 = cleared)
//   pos_neg       polarity select for shrinker input mux (0 = clk, 1 = ~clk)
//   busy          high from accept until DONE is left
//   ready         results valid, held until finish
//   avg_pos       averaged high-phase count
//   avg_neg       averaged low-phase count
//   diff          avg_pos - avg_neg, two's complement
//   bubble_err    sticky per run: some captured code was not a thermometer code
//   state_dbg     current FSM state, for observation only
//
// Handshake: request is a level that is sampled only in IDLE; a high level at
// an edge in IDLE is the accept. ready stays high in DONE until finish is seen
// high at an edge; finish takes priority over request in DONE, and a new
// request is only considered once the FSM is back in IDLE.
// ----------------------------------------------------------------------------
module dcm_avg_ctrl #(
    parameter int LEVEL        = 20,
    parameter int SAMPLES_LOG2 = 2,
    parameter int CLEAR_CYC    = 2,
    parameter int SETTLE       = 7,
    localparam int CW          = $clog2(LEVEL + 1)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             request,
    input  logic             finish,
    input  logic [1:0]       mode,
    input  logic [LEVEL-1:0] theta,
    output logic             shrinker_rst,
    output logic             pos_neg,
    output logic             busy,
    output logic             ready,
    output logic [CW-1:0]    avg_pos,
    output logic [CW-1:0]    avg_neg,
    output logic [CW:0]      diff,
    output logic             bubble_err,
    output logic [2:0]       state_dbg
);

    localparam int AW    = CW + SAMPLES_LOG2;
    localparam int N     = 1 << SAMPLES_LOG2;
    localparam int IW    = SAMPLES_LOG2 + 1;
    localparam int TMAX  = (CLEAR_CYC > SETTLE) ? CLEAR_CYC : SETTLE;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_ARM      = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE_PRE = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [TW-1:0]   tmr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc;
    logic [1:0]      mode_q;
    logic [AW-1:0]   acc_pos;
    logic [AW-1:0]   acc_neg;

    logic [CW-1:0]   lead_cnt;
    logic            seen_zero;
    logic            bubble_hit;

    logic            clear_done;
    logic            arm_done;
    logic            last_sample;
    logic            switch_pol;
    logic [CW-1:0]   avg_pos_nxt;
    logic [CW-1:0]   avg_neg_nxt;

    // Leading-ones count from bit 0; any 1 above the first 0 is a bubble.
    always_comb begin
        lead_cnt   = '0;
        seen_zero  = 1'b0;
        bubble_hit = 1'b0;
        for (int i = 0; i < LEVEL; i++) begin
            if (!seen_zero) begin
                if (theta[i]) lead_cnt = lead_cnt + CW'(1);
                else          seen_zero = 1'b1;
            end else if (theta[i]) begin
                bubble_hit = 1'b1;
            end
        end
    end

    assign clear_done  = (tmr == TW'(CLEAR_CYC - 1));
    assign arm_done    = (tmr == TW'(SETTLE - 1));
    assign idx_inc     = idx + IW'(1);
    assign last_sample = (idx_inc == IW'(N));
    // Finished the high-phase batch of a two-polarity run: go measure low phase.
    assign switch_pol  = last_sample && mode_q[1] && !pos_neg;

    assign avg_pos_nxt = acc_pos[AW-1:SAMPLES_LOG2];
    assign avg_neg_nxt = acc_neg[AW-1:SAMPLES_LOG2];

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (request) next_state = S_CLEAR;
            S_CLEAR:    if (clear_done) next_state = S_ARM;
            S_ARM:      if (arm_done) next_state = S_CAPTURE;
            S_CAPTURE:  begin
                if (!last_sample || switch_pol) next_state = S_CLEAR;
                else                            next_state = S_DONE_PRE;
            end
            S_DONE_PRE: next_state = S_DONE;
            S_DONE:     if (finish) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Shrinker runs only in ARM and CAPTURE; decoded from state so that an
    // asynchronous reset forces it high at once.
    assign shrinker_rst = !((state == S_ARM) || (state == S_CAPTURE));
    assign busy         = (state != S_IDLE);
    assign ready        = (state == S_DONE);
    assign state_dbg    = state;

    // Datapath: timers, sample index, accumulators and published results
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tmr        <= '0;
            idx        <= '0;
            mode_q     <= '0;
            pos_neg    <= 1'b0;
            acc_pos    <= '0;
            acc_neg    <= '0;
            avg_pos    <= '0;
            avg_neg    <= '0;
            diff       <= '0;
            bubble_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        tmr        <= '0;
                        idx        <= '0;
                        mode_q     <= mode;
                        pos_neg    <= (mode == 2'd1);
                        acc_pos    <= '0;
                        acc_neg    <= '0;
                        bubble_err <= 1'b0;
                    end
                end
                S_CLEAR: tmr <= clear_done ? '0 : tmr + TW'(1);
                S_ARM:   tmr <= arm_done   ? '0 : tmr + TW'(1);
                S_CAPTURE: begin
                    if (pos_neg) acc_neg <= acc_neg + AW'(lead_cnt);
                    else         acc_pos <= acc_pos + AW'(lead_cnt);
                    bubble_err <= bubble_err | bubble_hit;
                    if (switch_pol) begin
                        pos_neg <= 1'b1;
                        idx     <= '0;
                    end else begin
                        idx     <= idx_inc;
                    end
                end
                S_DONE_PRE: begin
                    avg_pos <= avg_pos_nxt;
                    avg_neg <= avg_neg_nxt;
                    diff    <= {1'b0, avg_pos_nxt} - {1'b0, avg_neg_nxt};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_avg_ctrl.sv
module tb_dcm_avg_ctrl;

  localparam int LEVEL = 20;
  localparam int NS    = 4;          // samples per polarity
  localparam int SAMPLE_CYC = 10;    // clear + settle + capture cycles

  // ---------------- clock / reset ----------------
  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             request = 1'b0;
  logic             finish = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [LEVEL-1:0] theta = '0;
  logic             shrinker_rst;
  logic             pos_neg;
  logic             busy;
  logic             ready;
  logic [4:0]       avg_pos;
  logic [4:0]       avg_neg;
  logic [5:0]       diff;
  logic             bubble_err;
  logic [2:0]       state_dbg;

  always #5 clk_in = ~clk_in;

  dcm_avg_ctrl dut (
    .clk_in(clk_in), .rst(rst), .request(request), .finish(finish),
    .mode(mode), .theta(theta), .shrinker_rst(shrinker_rst),
    .pos_neg(pos_neg), .busy(busy), .ready(ready), .avg_pos(avg_pos),
    .avg_neg(avg_neg), .diff(diff), .bubble_err(bubble_err),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // Codes presented to the shrinker, in capture order for the current run.
  logic [LEVEL-1:0] pat[2*NS];
  int pulse_idx = 0;
  int low_cnt = 0;
  int pulse_q[$];

  // Shrinker stand-in: each time shrinker_rst drops, present the next code.
  // Low-pulse lengths are recorded for checking.
  always @(negedge clk_in) begin
    if (rst) begin
      low_cnt = 0;
    end else if (!shrinker_rst) begin
      if (low_cnt == 0) begin
        theta = pat[pulse_idx % (2*NS)];
        pulse_idx++;
      end
      low_cnt++;
    end else if (low_cnt > 0) begin
      pulse_q.push_back(low_cnt);
      low_cnt = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: leading ones = (bits that flip when adding 1) - 1.
  function automatic int lead(input logic [LEVEL-1:0] t);
    logic [LEVEL:0] x;
    x = {1'b0, t};
    return $countones(x ^ (x + 1'b1)) - 1;
  endfunction

  // Run one measurement and check results, latency and shrinker pulses.
  // poke pulses request mid-run, which must have no effect.
  task automatic do_run(input logic [1:0] m, input bit poke, input string tag);
    int p, n, c, sum_p, sum_n, ap, an;
    bit bub;
    logic [5:0] ed;
    p = (m >= 2'd2) ? 2 : 1;
    sum_p = 0; sum_n = 0; bub = 1'b0;
    for (int i = 0; i < p*NS; i++) begin
      c = lead(pat[i]);
      if (int'(pat[i]) != ((1 << c) - 1)) bub = 1'b1;
      if (m == 2'd1 || (m >= 2'd2 && i >= NS)) sum_n += c;
      else                                     sum_p += c;
    end
    ap = sum_p / NS;
    an = sum_n / NS;
    ed = 6'(ap - an);

    pulse_q.delete();
    pulse_idx = 0;
    mode = m;
    request = 1'b1;
    tick();
    request = 1'b0;
    mode = 2'($urandom_range(0, 3));  // must be ignored after accept
    check({tag, "_busy"}, busy, 1);
    check({tag, "_pol_start"}, pos_neg, (m == 2'd1));
    n = 0;
    while (!ready && n < 300) begin
      request = (poke && n == 5);
      tick();
      n++;
    end
    request = 1'b0;
    check({tag, "_latency"}, n, p*NS*SAMPLE_CYC + 1);
    check({tag, "_avg_pos"}, avg_pos, ap);
    check({tag, "_avg_neg"}, avg_neg, an);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bubble"}, bubble_err, bub);
    check({tag, "_pulses"}, pulse_q.size(), p*NS);
    // The shrinker stays released through the settle cycles and the capture cycle.
    foreach (pulse_q[k]) check({tag, "_pulse_len"}, pulse_q[k], 8);
  endtask

  task automatic do_finish(input string tag);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check({tag, "_ready_clr"}, ready, 0);
    check({tag, "_busy_clr"}, busy, 0);
  endtask

  task automatic fill(input logic [LEVEL-1:0] a, input logic [LEVEL-1:0] b);
    for (int i = 0; i < 2*NS; i++) pat[i] = (i < NS) ? a : b;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, c;
    logic [LEVEL-1:0] t;

    fill('0, '0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_shrinker_rst", shrinker_rst, 1);
    check("rst_pos_neg", pos_neg, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_avg_pos", avg_pos, 0);
    check("rst_avg_neg", avg_neg, 0);
    check("rst_diff", diff, 0);
    check("rst_bubble", bubble_err, 0);

    // high phase only, constant 10 ones
    fill(20'h003FF, 20'h003FF);
    do_run(2'd0, 1'b0, "t2");
    do_finish("t2");

    // both phases, 12 then 7 ones
    fill(20'h00FFF, 20'h0007F);
    do_run(2'd2, 1'b0, "t3");
    do_finish("t3");

    // truncation: 5,6,6,6 -> 23/4 = 5
    pat[0] = 20'h0001F; pat[1] = 20'h0003F; pat[2] = 20'h0003F; pat[3] = 20'h0003F;
    do_run(2'd0, 1'b0, "t4a");
    do_finish("t4a");
    fill(20'hFFFFF, 20'hFFFFF);
    do_run(2'd0, 1'b0, "t4b");
    do_finish("t4b");

    // low phase only with a bubbled code
    fill(20'h0005F, 20'h0005F);
    do_run(2'd1, 1'b0, "t5");
    do_finish("t5");

    // request pulsed while busy, then request+finish together in DONE
    fill(20'h000FF, 20'h0000F);
    do_run(2'd3, 1'b1, "t6");
    request = 1'b1;
    finish = 1'b1;
    tick();
    request = 1'b0;
    finish = 1'b0;
    check("t6_ready_clr", ready, 0);
    check("t6_busy_clr", busy, 0);
    repeat (3) tick();
    check("t6_no_restart", busy, 0);
    check("t6_hold_avg_pos", avg_pos, 8);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 2*NS; i++) begin
        c = $urandom_range(0, LEVEL);
        t = LEVEL'((64'd1 << c) - 64'd1);
        if (c < LEVEL - 1 && $urandom_range(0, 3) == 0)
          t[$urandom_range(c + 1, LEVEL - 1)] = 1'b1;
        pat[i] = t;
      end
      do_run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
      do_finish("rnd");
    end

    // asynchronous reset while the shrinker is armed
    fill(20'h0FFFF, 20'h0FFFF);
    pulse_idx = 0;
    mode = 2'd2;
    request = 1'b1;
    tick();
    request = 1'b0;
    n = 0;
    while (shrinker_rst && n < 50) begin
      tick();
      n++;
    end
    check("t1_reached_arm", shrinker_rst, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t1_shrinker_rst", shrinker_rst, 1);
    check("t1_busy", busy, 0);
    check("t1_ready", ready, 0);
    check("t1_pos_neg", pos_neg, 0);
    check("t1_avg_pos", avg_pos, 0);
    check("t1_avg_neg", avg_neg, 0);
    check("t1_diff", diff, 0);
    check("t1_bubble", bubble_err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t1_idle_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
